// File: rtl/des_sbox_pipe.sv
// des_sbox_pipe: LANES-wide DES S-box substitution feeding a stallable valid/ready pipeline.
// Define DES_SBOX_PERM_EN to apply the DES P permutation to each lane result before stage 0.
module des_sbox_pipe #(
    parameter int LANES      = 1,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [48*LANES-1:0]             in_data,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [32*LANES-1:0]             out_data,
    output logic [TAG_W-1:0]                out_tag,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] in_flight
);
    localparam int DW = 32*LANES;
    localparam int CW = $clog2(PIPE_DEPTH+1);

    // One 64-entry table per box, row-major (row = {b5,b0}, col = b4..b1), entry 0 in the top nibble.
    localparam logic [0:7][255:0] SBOX = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

`ifdef DES_SBOX_PERM_EN
    localparam int PERM [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                  2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
`endif

    logic [5:0]    box_in;
    logic [31:0]   lane_raw;
    logic [DW-1:0] sub_data;

    always_comb begin
        sub_data = '0;
        lane_raw = '0;
        box_in   = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 8; j++) begin
                box_in = in_data[48*k+47-6*j -: 6];
                // Entry n sits at bits [255-4n -: 4]; 255-4n is {~n, 2'b11} for a 6-bit n.
                lane_raw[31-4*j -: 4] = SBOX[j][{~{box_in[5], box_in[0], box_in[4:1]}, 2'b11} -: 4];
            end
`ifdef DES_SBOX_PERM_EN
            for (int i = 0; i < 32; i++) begin
                sub_data[32*k+31-i] = lane_raw[32-PERM[i]];
            end
`else
            sub_data[32*k+31 -: 32] = lane_raw;
`endif
        end
    end

    logic [PIPE_DEPTH-1:0]            vld;
    logic [PIPE_DEPTH-1:0][DW-1:0]    dat;
    logic [PIPE_DEPTH-1:0][TAG_W-1:0] tag;
    logic [PIPE_DEPTH-1:0]            load;
    logic [PIPE_DEPTH-1:0]            up_valid;
    logic [PIPE_DEPTH-1:0][DW-1:0]    up_data;
    logic [PIPE_DEPTH-1:0][TAG_W-1:0] up_tag;

    assign up_valid[0] = in_valid;
    assign up_data[0]  = sub_data;
    assign up_tag[0]   = in_tag;

    for (genvar s = 1; s < PIPE_DEPTH; s++) begin : g_chain
        assign up_valid[s] = vld[s-1];
        assign up_data[s]  = dat[s-1];
        assign up_tag[s]   = tag[s-1];
    end

    // A stage loads when it is empty or its occupant moves on, so bubbles close up behind a stall.
    always_comb begin
        load = '0;
        load[PIPE_DEPTH-1] = !vld[PIPE_DEPTH-1] || out_ready;
        for (int s = PIPE_DEPTH-2; s >= 0; s--) begin
            load[s] = !vld[s] || load[s+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
            tag <= '0;
        end else begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (load[s]) begin
                    vld[s] <= up_valid[s];
                    // NOTE: payload is captured only with a valid beat, so a held stage never changes.
                    if (up_valid[s]) begin
                        dat[s] <= up_data[s];
                        tag[s] <= up_tag[s];
                    end
                end
            end
        end
    end

    assign in_ready  = !rst && load[0];
    assign out_valid = vld[PIPE_DEPTH-1];
    assign out_data  = dat[PIPE_DEPTH-1];
    assign out_tag   = tag[PIPE_DEPTH-1];
    assign in_flight = CW'($countones(vld));

endmodule
